hazard_ctrl: RTL



---
 rtl/hazard_pkg.sv | 18 +
 rtl/mdu_seq.sv | 67 ++++++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller.
//   fwd_sel_t   - E-stage forwarding mux select (RF / W result / M ALU result)
//   mdu_state_t - MDU occupancy sequencer states
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/mdu_seq.sv
// mdu_seq: MDU occupancy sequencer. Keeps a mul/div op in E for MDU_LAT
// cycles (MDU_LAT-1 stalled cycles plus one DONE cycle when memory is idle).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   mdu_start_i     E instruction is a mul/div op
//   stall_e_i       E register is frozen this cycle
//   mdu_busy_o      sequencer in BUSY
//   mdu_done_o      sequencer in DONE, result valid
//   mdustall_o      MDU requests a stall of F/D/E
module mdu_seq
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mdu_start_i,
    input  logic stall_e_i,
    output logic mdu_busy_o,
    output logic mdu_done_o,
    output logic mdustall_o
);

    localparam int unsigned CNT_W = $clog2(MDU_LAT);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mdu_start_i) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(MDU_LAT - 3);
                end
            end
            BUSY: begin
                // Counting continues through memory stalls; DONE absorbs the wait.
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            DONE: begin
                // Leave only when E advances, so a start held by a frozen E
                // cannot retrigger the op.
                if (!stall_e_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mdu_busy_o = (state_q == BUSY);
    assign mdu_done_o = (state_q == DONE);
    assign mdustall_o = ((state_q == IDLE) && mdu_start_i) || (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit. Drives stall (en = ~stall) and flush
// (clear) of the F/D/E/M/W registers and the E-stage forwarding muxes.
// Hazards by priority: memory wait, MDU occupancy, taken branch, load-use.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rs1D, rs2D / rs1E, rs2E    source registers in D / E
//   rdE, rdM, rdW              destination registers in E / M / W
//   loadE, regwriteM/W         load in E, register write in M / W
//   pcsrcE                     taken branch/jump resolved in E
//   mdu_startE                 mul/div op in E
//   dmem_reqM, dmem_readyM     data memory request / completion in M
//   forwardAE, forwardBE       forwarding selects for rs1E / rs2E
//   stallF..M, flushD..W       pipeline register freeze / bubble
//   mdu_busy, mdu_done         MDU sequencer status
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned REG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              loadE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              pcsrcE,
    input  logic              mdu_startE,
    input  logic              dmem_reqM,
    input  logic              dmem_readyM,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              mdu_busy,
    output logic              mdu_done
);

    logic memstall, lwstall, mdustall;

    function automatic fwd_sel_t fwd_pick(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        if (we_m && (rd_m != '0) && (rd_m == rs))      return FWD_M;
        else if (we_w && (rd_w != '0) && (rd_w == rs)) return FWD_W;
        else                                           return FWD_RF;
    endfunction

    assign forwardAE = fwd_pick(rs1E, rdM, regwriteM, rdW, regwriteW);
    assign forwardBE = fwd_pick(rs2E, rdM, regwriteM, rdW, regwriteW);

    assign memstall = dmem_reqM && !dmem_readyM;
    assign lwstall  = loadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

    mdu_seq #(.MDU_LAT(MDU_LAT)) u_mdu_seq (
        .clk        (clk),
        .reset      (reset),
        .mdu_start_i(mdu_startE),
        .stall_e_i  (stallE),
        .mdu_busy_o (mdu_busy),
        .mdu_done_o (mdu_done),
        .mdustall_o (mdustall)
    );

    // Exactly one hazard row applies; a stalled register is never also cleared.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (memstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (mdustall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (pcsrcE) begin
            // D holds a wrong-path instruction, so its load-use hazard is moot.
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (lwstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

endmodule
